// File: rtl/pair_triple_sample_window_pkg.sv
// Shared encodings for the pair/triple sample window: FSM states and window stride modes.
package pair_triple_sample_window_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  localparam int MODE_SLIDE = 0;
  localparam int MODE_BLOCK = 1;

endpackage

// File: rtl/pair_triple_sample_window_shreg.sv
// 3-bit sample shift register; taps[0] is the newest sample, taps[2] the oldest.
module pair_triple_sample_window_shreg (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       din,
  output logic [2:0] taps
);

  logic [2:0] taps_q;
  logic [2:0] taps_d;

  always_comb begin
    taps_d = taps_q;
    if (clear) begin
      taps_d = 3'b000;
    end else if (shift_en) begin
      taps_d = {taps_q[1:0], din};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps_q <= 3'b000;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign taps = taps_q;

endmodule

// File: rtl/pair_triple_sample_window.sv
// Serial-to-window feeder for the 2-of-3 majority detector, sliding or blocked stride.
module pair_triple_sample_window
  import pair_triple_sample_window_pkg::*;
#(
  parameter int BLOCK_MODE = MODE_SLIDE,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic             in_bit,
  output logic             out_val,
  input  logic             out_rdy,
  output logic             out0,
  output logic             out1,
  output logic             out2,
  output logic [1:0]       fill,
  output logic [CNT_W-1:0] win_count
);

  // Handshakes: a side fires only on the edge where its valid and ready are both high.
  state_e             state_q, state_d;
  logic [1:0]         fill_q, fill_d;
  logic               presented_q, presented_d;
  logic [CNT_W-1:0]   win_count_q, win_count_d;
  logic [2:0]         taps;
  logic               in_fire;
  logic               out_fire;

  // A full window blocks new bits unless the consumer takes it this same cycle.
  assign in_rdy   = !clear && ((state_q == ST_FILL) || out_rdy);
  assign out_val  = !clear && (state_q == ST_FULL) && !presented_q;
  assign in_fire  = in_val && in_rdy;
  assign out_fire = out_val && out_rdy;

  pair_triple_sample_window_shreg u_shreg (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .shift_en (in_fire),
    .din      (in_bit),
    .taps     (taps)
  );

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    presented_d = presented_q;
    win_count_d = win_count_q;
    if (clear) begin
      state_d     = ST_FILL;
      fill_d      = 2'd0;
      presented_d = 1'b0;
      win_count_d = '0;
    end else begin
      if (out_fire) begin
        win_count_d = win_count_q + CNT_W'(1);
      end
      case (state_q)
        ST_FILL: begin
          if (in_fire) begin
            fill_d      = fill_q + 2'd1;
            presented_d = 1'b0;
            if (fill_q == 2'd2) begin
              state_d = ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (BLOCK_MODE == MODE_BLOCK) begin
            // The bit arriving alongside a handoff opens the next block.
            if (out_fire) begin
              state_d = ST_FILL;
              fill_d  = in_fire ? 2'd1 : 2'd0;
            end
          end else begin
            if (in_fire) begin
              presented_d = 1'b0;
            end else if (out_fire) begin
              presented_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_FILL;
          fill_d  = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      fill_q      <= 2'd0;
      presented_q <= 1'b0;
      win_count_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      presented_q <= presented_d;
      win_count_q <= win_count_d;
    end
  end

  assign out0      = taps[0];
  assign out1      = taps[1];
  assign out2      = taps[2];
  assign fill      = fill_q;
  assign win_count = win_count_q;

endmodule

// File: tb/tb_pair_triple_sample_window.sv
// Directed bench: sliding (CNT_W=8), block mode, and sliding CNT_W=2 instances share stimulus.
module tb_pair_triple_sample_window;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic in_val = 1'b0;
  logic in_bit = 1'b0;
  logic out_rdy = 1'b0;

  logic       s_in_rdy, s_out_val, s_out0, s_out1, s_out2;
  logic [1:0] s_fill;
  logic [7:0] s_cnt;
  logic       b_in_rdy, b_out_val, b_out0, b_out1, b_out2;
  logic [1:0] b_fill;
  logic [7:0] b_cnt;
  logic       c_in_rdy, c_out_val, c_out0, c_out1, c_out2;
  logic [1:0] c_fill;
  logic [1:0] c_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pair_triple_sample_window #(.BLOCK_MODE(0), .CNT_W(8)) u_slide (
    .clk(clk), .rst(rst), .clear(clear), .in_val(in_val), .in_rdy(s_in_rdy),
    .in_bit(in_bit), .out_val(s_out_val), .out_rdy(out_rdy), .out0(s_out0),
    .out1(s_out1), .out2(s_out2), .fill(s_fill), .win_count(s_cnt)
  );

  pair_triple_sample_window #(.BLOCK_MODE(1), .CNT_W(8)) u_block (
    .clk(clk), .rst(rst), .clear(clear), .in_val(in_val), .in_rdy(b_in_rdy),
    .in_bit(in_bit), .out_val(b_out_val), .out_rdy(out_rdy), .out0(b_out0),
    .out1(b_out1), .out2(b_out2), .fill(b_fill), .win_count(b_cnt)
  );

  pair_triple_sample_window #(.BLOCK_MODE(0), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .clear(clear), .in_val(in_val), .in_rdy(c_in_rdy),
    .in_bit(in_bit), .out_val(c_out_val), .out_rdy(out_rdy), .out0(c_out0),
    .out1(c_out1), .out2(c_out2), .fill(c_fill), .win_count(c_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are checked 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear = 1'b0;
    in_val = 1'b0;
    in_bit = 1'b0;
    out_rdy = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic push(input logic b);
    in_val = 1'b1;
    in_bit = b;
    step();
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_in_rdy", 32'(s_in_rdy), 32'd1);
    chk("rst_out_val", 32'(s_out_val), 32'd0);
    chk("rst_fill", 32'(s_fill), 32'd0);
    chk("rst_cnt", 32'(s_cnt), 32'd0);
    chk("rst_win", 32'({s_out2, s_out1, s_out0}), 32'd0);

    // Sliding: bits 1,1,0,1
    out_rdy = 1'b1;
    push(1'b1);
    chk("sl_b1_val", 32'(s_out_val), 32'd0);
    push(1'b1);
    chk("sl_b2_val", 32'(s_out_val), 32'd0);
    chk("sl_b2_fill", 32'(s_fill), 32'd2);
    push(1'b0);
    chk("sl_b3_val", 32'(s_out_val), 32'd1);
    chk("sl_b3_win", 32'({s_out2, s_out1, s_out0}), 32'b110);
    chk("sl_b3_fill", 32'(s_fill), 32'd3);
    push(1'b1);
    chk("sl_b4_val", 32'(s_out_val), 32'd1);
    chk("sl_b4_win", 32'({s_out2, s_out1, s_out0}), 32'b101);
    chk("sl_b4_cnt", 32'(s_cnt), 32'd1);
    in_val = 1'b0;
    step();
    chk("sl_end_cnt", 32'(s_cnt), 32'd2);
    chk("sl_end_val", 32'(s_out_val), 32'd0);
    chk("sl_end_win", 32'({s_out2, s_out1, s_out0}), 32'b101);
    step();
    chk("sl_once_cnt", 32'(s_cnt), 32'd2);

    // Block mode: bits 1,0,1,0,0,1
    do_reset();
    out_rdy = 1'b1;
    push(1'b1);
    push(1'b0);
    push(1'b1);
    chk("bk_w1_val", 32'(b_out_val), 32'd1);
    chk("bk_w1_win", 32'({b_out2, b_out1, b_out0}), 32'b101);
    push(1'b0);
    chk("bk_b4_val", 32'(b_out_val), 32'd0);
    chk("bk_b4_fill", 32'(b_fill), 32'd1);
    chk("bk_b4_cnt", 32'(b_cnt), 32'd1);
    push(1'b0);
    chk("bk_b5_val", 32'(b_out_val), 32'd0);
    chk("bk_b5_fill", 32'(b_fill), 32'd2);
    push(1'b1);
    chk("bk_w2_val", 32'(b_out_val), 32'd1);
    chk("bk_w2_win", 32'({b_out2, b_out1, b_out0}), 32'b001);
    in_val = 1'b0;
    step();
    chk("bk_end_cnt", 32'(b_cnt), 32'd2);
    chk("bk_end_val", 32'(b_out_val), 32'd0);
    chk("bk_end_fill", 32'(b_fill), 32'd0);

    // Backpressure on a stalled 011 window
    do_reset();
    out_rdy = 1'b1;
    push(1'b0);
    push(1'b1);
    push(1'b1);
    chk("bp_win", 32'({s_out2, s_out1, s_out0}), 32'b011);
    out_rdy = 1'b0;
    in_val = 1'b1;
    in_bit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_rdy", 32'(s_in_rdy), 32'd0);
      step();
      chk("bp_hold_win", 32'({s_out2, s_out1, s_out0}), 32'b011);
      chk("bp_hold_val", 32'(s_out_val), 32'd1);
      chk("bp_hold_cnt", 32'(s_cnt), 32'd0);
    end
    in_val = 1'b0;
    out_rdy = 1'b1;
    step();
    chk("bp_rel_cnt", 32'(s_cnt), 32'd1);
    chk("bp_rel_val", 32'(s_out_val), 32'd0);
    step();
    chk("bp_rel_cnt2", 32'(s_cnt), 32'd1);

    // clear with fill=2, then 111
    do_reset();
    out_rdy = 1'b1;
    push(1'b1);
    push(1'b0);
    chk("cl_pre_fill", 32'(s_fill), 32'd2);
    clear = 1'b1;
    in_val = 1'b1;
    #1;
    chk("cl_in_rdy", 32'(s_in_rdy), 32'd0);
    chk("cl_out_val", 32'(s_out_val), 32'd0);
    step();
    clear = 1'b0;
    in_val = 1'b0;
    #1;
    chk("cl_fill", 32'(s_fill), 32'd0);
    chk("cl_val", 32'(s_out_val), 32'd0);
    out_rdy = 1'b0;
    push(1'b1);
    push(1'b1);
    push(1'b1);
    in_val = 1'b0;
    chk("cl_new_val", 32'(s_out_val), 32'd1);
    chk("cl_new_win", 32'({s_out2, s_out1, s_out0}), 32'b111);

    // Async reset while FULL, no clock edge involved
    #2;
    rst = 1'b1;
    #1;
    chk("ar_val", 32'(s_out_val), 32'd0);
    chk("ar_win", 32'({s_out2, s_out1, s_out0}), 32'd0);
    chk("ar_fill", 32'(s_fill), 32'd0);
    rst = 1'b0;
    #1;
    chk("ar_in_rdy", 32'(s_in_rdy), 32'd1);
    chk("ar_fill2", 32'(s_fill), 32'd0);

    // CNT_W=2 wrap: counts 1,2,3,0,1
    do_reset();
    out_rdy = 1'b1;
    push(1'b1);
    push(1'b0);
    push(1'b1);
    chk("wr_cnt0", 32'(c_cnt), 32'd0);
    push(1'b0);
    chk("wr_cnt1", 32'(c_cnt), 32'd1);
    push(1'b1);
    chk("wr_cnt2", 32'(c_cnt), 32'd2);
    push(1'b1);
    chk("wr_cnt3", 32'(c_cnt), 32'd3);
    push(1'b0);
    chk("wr_cnt4", 32'(c_cnt), 32'd0);
    push(1'b0);
    chk("wr_cnt5", 32'(c_cnt), 32'd1);
    chk("wr_win", 32'({c_out2, c_out1, c_out0}), 32'b100);
    in_val = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pair_triple_sample_window.md
Name: pair_triple_sample_window

Overview:
- Upstream feeder for the pair/triple (2-of-3 majority) detector.
- Collects a serial bit stream into a 3-bit window and presents the three taps as parallel outputs, with a valid/ready handshake on both sides.
- Supports sliding windows (one new window per input bit) and blocked windows (non-overlapping groups of 3).
- Keeps a wrapping count of windows issued, for debug and performance counters.

Parameters:
- BLOCK_MODE, 0, 0 = sliding window (stride 1); 1 = non-overlapping window (stride 3)
- CNT_W, 8, width of the issued-window counter

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous flush; returns the block to its reset state at the next edge
- in_val  input  1  upstream bit valid
- in_rdy  output  1  block can accept in_bit this cycle
- in_bit  input  1  serial sample
- out_val  output  1  window valid
- out_rdy  input  1  downstream consumer accepts the window
- out0  output  1  newest sample in the window (drives detector in0)
- out1  output  1  middle sample (drives detector in1)
- out2  output  1  oldest sample (drives detector in2)
- fill  output  2  samples currently held toward the next window (0..3)
- win_count  output  CNT_W  windows handed off; wraps modulo 2^CNT_W

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset (async, rst=1): state=FILL, window=3'b000, fill=0, win_count=0, out_val=0, in_rdy=1 once rst deasserts.
- Handshakes: input fires on in_val && in_rdy; output fires on out_val && out_rdy.
- Input fire shifts the window: {out2,out1,out0} <= {out1,out0,in_bit}.
- State FILL (fill<3):
  - out_val=0, in_rdy=1.
  - Input fire: fill+=1; when fill reaches 3, go to FULL at the same edge.
- State FULL (fill==3):
  - out_val=1; window is held stable while out_rdy=0.
  - in_rdy = out_rdy, so a stalled window is never overwritten.
  - Output fire: win_count+=1.
- Sliding mode (BLOCK_MODE=0):
  - Output fire with a simultaneous input fire: shift, stay in FULL, fill stays 3. The new window is valid next cycle (one window per bit at full throughput).
  - Output fire without an input fire: stay in FULL, window retained, fill=3, out_val drops to 0 until the next input fire, then returns to 1. Each distinct window is presented exactly once.
  - A per-window "presented" flag, cleared on shift and set on output fire, gates out_val.
- Block mode (BLOCK_MODE=1):
  - Output fire without an input fire: fill <= 0, go to FILL.
  - Output fire with a simultaneous input fire: the bit is the first of the next block; fill <= 1, go to FILL.
- Latency: a window is presented the cycle after the input fire that completes it (registered outputs, no combinational in_bit->out path).
- Combinational paths: in_rdy depends combinationally on out_rdy and state only; out_val is registered state gated by clear.
- clear=1:
  - in_rdy=0 and out_val=0 combinationally, so no handshake fires.
  - Next edge: all state returns to reset values.
  - clear overrides any pending or stalled window; rst overrides clear.
- Reset mid-window: partial samples are discarded; win_count returns to 0.
- win_count wraps from 2^CNT_W-1 to 0 with no flag.
- in_bit is ignored when no input fire occurs.

Decomposition:
- Shared header: state encodings (FILL, FULL) as localparams, plus the BLOCK_MODE values (MODE_SLIDE=0, MODE_BLOCK=1).
- One sub-module, sample_window_shreg: 3-bit shift register with async reset, sync clear and shift-enable. It provides the taps out0..out2.
- FSM, fill counter, presented flag and win_count stay in the top module.

Test Plan:
- Sliding, out_rdy=1, bits 1,1,0,1: no out_val for the first two bits.
  - After the 3rd bit: {out2,out1,out0}=110, out_val=1.
  - After the 4th bit: 101.
  - win_count ends at 2.
- Block mode, out_rdy=1, bits 1,0,1,0,0,1: windows 101 then 001 only; no window formed from overlapping samples; win_count ends at 2.
- Backpressure:
  - Window 011 valid, out_rdy=0 for 5 cycles with in_val=1: in_rdy=0, window stays 011.
  - Raise out_rdy: the handshake fires once and win_count increments by exactly 1.
- clear with fill=2: the next cycle shows fill=0 and out_val=0. Three new bits 111 then produce window 111.
- Async rst asserted mid-cycle while FULL: outputs go to 0 without a clock edge; after release, in_rdy=1 and fill=0.
- CNT_W=2, 5 sliding windows accepted: win_count sequence 1,2,3,0,1.
